// File: rtl/id_issue_queue.sv
// id_issue_queue: decode front-end between IF and EX; FIFO-buffers fetched instructions,
// pre-decodes the head and issues it through a registered valid/ready stage with
// load-use bubble insertion, delay-slot tagging, flush and branch redirect.
// Ports: clk/rst_n (sync, active low); if_* fetch handshake; flush_i/redirect_i control;
// ex_ready_i EX back-pressure; id_* registered issue stage; stall_cnt_o load-use bubbles.
module id_issue_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [XLEN-1:0]  if_pc_i,
  input  logic [XLEN-1:0]  if_inst_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic             ex_ready_i,
  output logic             id_valid_o,
  output logic [XLEN-1:0]  id_pc_o,
  output logic [XLEN-1:0]  id_inst_o,
  output logic [4:0]       id_rs_o,
  output logic [4:0]       id_rt_o,
  output logic             id_rs_read_o,
  output logic             id_rt_read_o,
  output logic [4:0]       id_wd_o,
  output logic             id_wreg_o,
  output logic             id_is_load_o,
  output logic             id_is_branch_o,
  output logic             id_in_dslot_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, LU_STALL, DSLOT} state_t;
  state_t state;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [XLEN-1:0] head_pc, head_inst;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wd;
  logic special, rs_read, rt_read, wreg, is_load, is_branch;
  logic head, hazard, keep, iss, enq;
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];
  assign op        = head_inst[31:26];
  assign funct     = head_inst[5:0];
  assign rs        = head_inst[25:21];
  assign rt        = head_inst[20:16];
  assign rd        = head_inst[15:11];
  assign special   = op == 6'h00;
  always_comb begin
    wd        = special ? rd : (op == 6'h03) ? 5'd31 : rt;
    rs_read   = !(op == 6'h02 || op == 6'h03 ||
                  (special && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03 ||
                               funct == 6'h10 || funct == 6'h12)));
    rt_read   = special ? !(funct inside {6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13})
                        : (op inside {6'h04, 6'h05, 6'h2b, 6'h28});
    is_load   = op inside {6'h20, 6'h23, 6'h24, 6'h25};
    // Non-SPECIAL writers are enumerated so undefined opcodes never write.
    wreg      = special ? !(funct inside {6'h08, 6'h11, 6'h13, 6'h18})
                        : (op == 6'h03 || (op >= 6'h08 && op <= 6'h0f) || is_load);
    is_branch = (op >= 6'h01 && op <= 6'h07) || (special && (funct == 6'h08 || funct == 6'h09));
  end
  assign head       = count != '0;
  assign if_ready_o = count != (AW+1)'(DEPTH);
  // The load in the output stage leaves this cycle; its consumer at the head must wait one cycle.
  assign hazard = id_valid_o && id_is_load_o && ex_ready_i && id_wd_o != 5'd0 && head &&
                  ((rs_read && rs == id_wd_o) || (rt_read && rt == id_wd_o));
  // Redirect while waiting for the delay slot keeps the head; otherwise the head is wrong-path.
  assign keep = state == DSLOT && head;
  assign iss  = head && (!id_valid_o || ex_ready_i) && !hazard && !flush_i && !(redirect_i && !keep);
  assign enq  = if_valid_i && if_ready_o && !flush_i && !redirect_i;
  always_ff @(posedge clk)
    if (enq) begin
      pc_mem[wr_ptr]   <= if_pc_i;
      inst_mem[wr_ptr] <= if_inst_i;
    end
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      wr_ptr <= keep ? rd_ptr + 1'b1 : '0;
      rd_ptr <= keep ? rd_ptr + AW'(iss) : '0;
      count  <= (keep && !iss) ? (AW+1)'(1) : '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(iss);
      count  <= count + (AW+1)'(enq) - (AW+1)'(iss);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_o     <= 1'b0;
      id_pc_o        <= '0;
      id_inst_o      <= '0;
      id_rs_o        <= '0;
      id_rt_o        <= '0;
      id_rs_read_o   <= 1'b0;
      id_rt_read_o   <= 1'b0;
      id_wd_o        <= '0;
      id_wreg_o      <= 1'b0;
      id_is_load_o   <= 1'b0;
      id_is_branch_o <= 1'b0;
      id_in_dslot_o  <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (iss) begin
      id_valid_o     <= 1'b1;
      id_pc_o        <= head_pc;
      id_inst_o      <= head_inst;
      id_rs_o        <= rs;
      id_rt_o        <= rt;
      id_rs_read_o   <= rs_read;
      id_rt_read_o   <= rt_read;
      id_wd_o        <= wd;
      id_wreg_o      <= wreg;
      id_is_load_o   <= is_load;
      id_is_branch_o <= is_branch;
      id_in_dslot_o  <= state == DSLOT;
    end else if (ex_ready_i) begin
      id_valid_o <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_o <= '0;
    else if (hazard && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) state <= RUN;
    else if (hazard) state <= LU_STALL;
    else if (iss) state <= (is_branch && state != DSLOT) ? DSLOT : RUN;
    else if (state == LU_STALL) state <= RUN;
  end
endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed self-checking bench for id_issue_queue.
module tb_id_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n, if_valid_i, if_ready_o, flush_i, redirect_i, ex_ready_i;
  logic [31:0] if_pc_i, if_inst_i, id_pc_o, id_inst_o;
  logic [4:0]  id_rs_o, id_rt_o, id_wd_o;
  logic        id_valid_o, id_rs_read_o, id_rt_read_o, id_wreg_o;
  logic        id_is_load_o, id_is_branch_o, id_in_dslot_o;
  logic [15:0] stall_cnt_o;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  id_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc_i), .if_inst_i(if_inst_i), .flush_i(flush_i), .redirect_i(redirect_i),
    .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_rs_o(id_rs_o), .id_rt_o(id_rt_o), .id_rs_read_o(id_rs_read_o), .id_rt_read_o(id_rt_read_o),
    .id_wd_o(id_wd_o), .id_wreg_o(id_wreg_o), .id_is_load_o(id_is_load_o),
    .id_is_branch_o(id_is_branch_o), .id_in_dslot_o(id_in_dslot_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
  endtask
  initial begin
    rst_n = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; ex_ready_i = 1'b0;
    offer(32'h0, r_op(5'd1, 5'd2, 5'd3, 6'h21));
    tick(); tick();
    check("rst_valid", 64'(id_valid_o), 64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    check("rst_ready", 64'(if_ready_o), 64'd1);
    check("rst_wd", 64'(id_wd_o), 64'd0);
    rst_n = 1'b1; if_valid_i = 1'b0;
    tick();
    check("rst_empty", 64'(id_valid_o), 64'd0);
    // back-to-back ALU stream, no bubble
    ex_ready_i = 1'b1;
    offer(32'h100, r_op(5'd1, 5'd2, 5'd3, 6'h21));
    tick();
    check("s2_latency", 64'(id_valid_o), 64'd0);
    offer(32'h104, i_op(6'h0d, 5'd3, 5'd4, 16'd5));
    tick();
    check("s2_addu_valid", 64'(id_valid_o), 64'd1);
    check("s2_addu_pc", 64'(id_pc_o), 64'h100);
    check("s2_addu_wd", 64'(id_wd_o), 64'd3);
    check("s2_addu_rt_read", 64'(id_rt_read_o), 64'd1);
    check("s2_addu_wreg", 64'(id_wreg_o), 64'd1);
    if_valid_i = 1'b0;
    tick();
    check("s2_ori_valid", 64'(id_valid_o), 64'd1);
    check("s2_ori_wd", 64'(id_wd_o), 64'd4);
    check("s2_ori_rs", 64'({id_rs_read_o, id_rs_o}), 64'h23);
    check("s2_ori_rt_read", 64'(id_rt_read_o), 64'd0);
    tick();
    check("s2_drained", 64'(id_valid_o), 64'd0);
    // load-use bubble
    offer(32'h200, i_op(6'h23, 5'd1, 5'd5, 16'd0));
    tick();
    offer(32'h204, r_op(5'd5, 5'd2, 5'd6, 6'h21));
    tick();
    check("s3_lw_load", 64'({id_valid_o, id_is_load_o}), 64'h3);
    check("s3_lw_wd", 64'(id_wd_o), 64'd5);
    if_valid_i = 1'b0;
    tick();
    check("s3_bubble", 64'(id_valid_o), 64'd0);
    check("s3_stall_cnt", 64'(stall_cnt_o), 64'd1);
    tick();
    check("s3_use_valid", 64'(id_valid_o), 64'd1);
    check("s3_use_pc", 64'(id_pc_o), 64'h204);
    check("s3_use_wd", 64'(id_wd_o), 64'd6);
    offer(32'h208, i_op(6'h23, 5'd1, 5'd0, 16'd0));
    tick();
    offer(32'h20c, r_op(5'd0, 5'd2, 5'd6, 6'h21));
    tick();
    check("s3_lw0_pc", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h208});
    if_valid_i = 1'b0;
    tick();
    check("s3_r0_nobubble", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h20c});
    check("s3_r0_stall_cnt", 64'(stall_cnt_o), 64'd1);
    tick();
    // branch, delay slot, redirect drops wrong path
    offer(32'h300, i_op(6'h04, 5'd1, 5'd2, 16'd4));
    tick();
    offer(32'h304, i_op(6'h09, 5'd0, 5'd7, 16'd1));
    tick();
    check("s4_beq_branch", 64'({id_valid_o, id_is_branch_o, id_in_dslot_o}), 64'h6);
    check("s4_beq_wreg", 64'(id_wreg_o), 64'd0);
    ex_ready_i = 1'b0;
    offer(32'h308, i_op(6'h0d, 5'd0, 5'd8, 16'd1));
    tick();
    offer(32'h30c, i_op(6'h0d, 5'd0, 5'd9, 16'd1));
    tick();
    redirect_i = 1'b1;
    offer(32'h310, i_op(6'h0d, 5'd0, 5'd10, 16'd1));
    tick();
    check("s4_redirect_hold", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h300});
    check("s4_redirect_ready", 64'(if_ready_o), 64'd1);
    redirect_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b1;
    tick();
    check("s4_dslot_pc", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h304});
    check("s4_dslot_tag", 64'(id_in_dslot_o), 64'd1);
    tick();
    check("s4_wrong_path_1", 64'(id_valid_o), 64'd0);
    tick();
    check("s4_wrong_path_2", 64'(id_valid_o), 64'd0);
    // fill to full under back-pressure, then drain in order across the pointer wrap
    ex_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'h400 + 32'(4 * i), i_op(6'h0d, 5'd0, 5'(10 + i), 16'd1));
      tick();
    end
    check("s5_full_ready", 64'(if_ready_o), 64'd0);
    check("s5_head_pc", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h400});
    offer(32'h414, i_op(6'h0d, 5'd0, 5'd15, 16'd1));
    tick();
    check("s5_full_hold_ready", 64'(if_ready_o), 64'd0);
    check("s5_stable", 64'({id_wd_o, id_pc_o}), {32'd10, 32'h400});
    if_valid_i = 1'b0; ex_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("s5_drain_%0d", i), 64'({id_valid_o, id_pc_o}), {32'd1, 32'h400 + 32'(4 * i)});
      check($sformatf("s5_drain_wd_%0d", i), 64'(id_wd_o), 64'(10 + i));
      if (i == 1) check("s5_ready_again", 64'(if_ready_o), 64'd1);
    end
    tick();
    check("s5_no_extra", 64'(id_valid_o), 64'd0);
    // flush beats redirect, enqueue and issue; FSM back to RUN
    offer(32'h500, i_op(6'h04, 5'd1, 5'd2, 16'd4));
    tick();
    offer(32'h504, i_op(6'h0d, 5'd0, 5'd8, 16'd1));
    tick();
    ex_ready_i = 1'b0;
    offer(32'h508, i_op(6'h0d, 5'd0, 5'd9, 16'd1));
    tick();
    flush_i = 1'b1; redirect_i = 1'b1; ex_ready_i = 1'b1;
    offer(32'h50c, i_op(6'h0d, 5'd0, 5'd10, 16'd1));
    tick();
    check("s6_flush_valid", 64'(id_valid_o), 64'd0);
    check("s6_flush_ready", 64'(if_ready_o), 64'd1);
    flush_i = 1'b0; redirect_i = 1'b0; if_valid_i = 1'b0;
    tick();
    check("s6_queue_empty", 64'(id_valid_o), 64'd0);
    offer(32'h600, r_op(5'd1, 5'd2, 5'd3, 6'h21));
    tick();
    if_valid_i = 1'b0;
    tick();
    check("s6_after_pc", 64'({id_valid_o, id_pc_o}), {32'd1, 32'h600});
    check("s6_run_no_dslot", 64'(id_in_dslot_o), 64'd0);
    check("s6_stall_kept", 64'(stall_cnt_o), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
